// File: rtl/operand_issue_stage.sv
// Operand fetch / issue stage between decode and execute.
// Reads operands from the register file, holds the issued instruction in an
// ID/EX output register, tracks pending destination writes in a busy
// scoreboard (stalling on RAW and WAW), and owns the register-file write port
// so that writeback data and busy release arrive through one place.
module operand_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [4:0]        in_rd_i,
  input  logic              in_use_rs1_i,
  input  logic              in_use_rs2_i,
  input  logic              in_wr_rd_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,

  output logic [4:0]        rf_rd_addr1_o,
  output logic [4:0]        rf_rd_addr2_o,
  input  logic [DATA_W-1:0] rf_rd_data1_i,
  input  logic [DATA_W-1:0] rf_rd_data2_i,

  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_op1_o,
  output logic [DATA_W-1:0] out_op2_o,
  output logic [4:0]        out_rd_o,
  output logic              out_wr_rd_o,
  output logic [CTRL_W-1:0] out_ctrl_o,

  input  logic              wb_valid_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              rf_wrt_en_o,
  output logic [4:0]        rf_wrt_addr_o,
  output logic [DATA_W-1:0] rf_wrt_data_o,

  input  logic              flush_i,
  output logic [31:0]       busy_vec_o
);

  logic [31:0]       busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_op1_q, out_op2_q;
  logic [4:0]        out_rd_q;
  logic              out_wr_rd_q;
  logic [CTRL_W-1:0] out_ctrl_q;

  logic              rs1_nz, rs2_nz, rd_nz, wb_rd_nz, out_rd_nz;
  logic              hazard;
  logic              issue;
  logic [DATA_W-1:0] op1_sel, op2_sel;

  assign rs1_nz    = (in_rs1_i != 5'd0);
  assign rs2_nz    = (in_rs2_i != 5'd0);
  assign rd_nz     = (in_rd_i != 5'd0);
  assign wb_rd_nz  = (wb_rd_i != 5'd0);
  assign out_rd_nz = (out_rd_q != 5'd0);

  // Hazard looks only at the registered scoreboard: a writeback in this
  // cycle does not unblock a dependent until the next cycle (no bypass).
  assign hazard = (in_use_rs1_i & rs1_nz & busy_q[in_rs1_i])
                | (in_use_rs2_i & rs2_nz & busy_q[in_rs2_i])
                | (in_wr_rd_i   & rd_nz  & busy_q[in_rd_i]);

  assign in_ready_o = ~flush_i & ~hazard & (~out_valid_q | out_ready_i);
  assign issue      = in_valid_i & in_ready_o;

  assign rf_rd_addr1_o = in_rs1_i;
  assign rf_rd_addr2_o = in_rs2_i;

  // x0 always reads as zero regardless of what the register file returns.
  assign op1_sel = rs1_nz ? rf_rd_data1_i : '0;
  assign op2_sel = rs2_nz ? rf_rd_data2_i : '0;

  assign rf_wrt_en_o   = wb_valid_i & wb_we_i & wb_rd_nz;
  assign rf_wrt_addr_o = wb_rd_i;
  assign rf_wrt_data_o = wb_data_i;

  // Scoreboard next state: writeback release, flush release of the killed
  // output-register writer, then set on issue. The WAW stall guarantees the
  // set never targets a bit being released in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i && wb_rd_nz) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    if (flush_i && out_valid_q && out_wr_rd_q && out_rd_nz) begin
      busy_d[out_rd_q] = 1'b0;
    end
    if (issue && in_wr_rd_i && rd_nz) begin
      busy_d[in_rd_i] = 1'b1;
    end
  end

  // Output-register valid: flush kills, issue fills, a consumed entry empties.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard and valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ID/EX payload: loads only on issue, otherwise holds (covers backpressure).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_wr_rd_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else if (issue) begin
      out_op1_q   <= op1_sel;
      out_op2_q   <= op2_sel;
      out_rd_q    <= in_rd_i;
      out_wr_rd_q <= in_wr_rd_i;
      out_ctrl_q  <= in_ctrl_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_op1_o   = out_op1_q;
  assign out_op2_o   = out_op2_q;
  assign out_rd_o    = out_rd_q;
  assign out_wr_rd_o = out_wr_rd_q;
  assign out_ctrl_o  = out_ctrl_q;
  assign busy_vec_o  = busy_q;

endmodule
